// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared constants and types for the vote logging / result reading blocks.
//   NUM_CAND     : number of candidates (fixed at 4)
//   CAND_IDX_W   : width of a candidate index
//   VOTE_WIDTH   : default width of a single candidate vote count
//   TOTAL_W      : width of the sum of all candidate counts (VOTE_WIDTH+2)
//   state_e      : result reader sequencing states
// -----------------------------------------------------------------------------
package vote_pkg;

  localparam int NUM_CAND   = 4;
  localparam int CAND_IDX_W = 2;
  localparam int VOTE_WIDTH = 8;
  localparam int TOTAL_W    = VOTE_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_REPORT  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage : vote_pkg

// File: rtl/vote_result_reader.sv
// -----------------------------------------------------------------------------
// vote_result_reader
// On a start request in result mode, snapshots the four live candidate
// counters, scans the snapshot one candidate per cycle to find winner, tie and
// total, then streams each candidate's count over a valid/ready handshake.
// Winner information is published only once the last beat has transferred.
//
// Ports:
//   clock          : system clock, rising edge active
//   reset          : asynchronous active-low reset
//   mode           : 0 = voting, 1 = result (block only runs while 1)
//   start          : single-cycle request to read and report results
//   candN_vote_rec : live vote counts from the logger (N = 1..4)
//   out_ready      : downstream accepts the current result beat
//   result_valid   : result_cand/result_count hold a valid beat
//   result_cand    : candidate index of the current beat
//   result_count   : snapshot count of result_cand
//   winner_valid   : winner outputs are final
//   winner_cand    : index of the highest count (lowest index on a tie)
//   winner_count   : highest count
//   tie            : at least two candidates share the highest count
//   total_votes    : sum of the four snapshot counts
//   busy           : read/report sequence in progress
// -----------------------------------------------------------------------------
module vote_result_reader
  import vote_pkg::*;
#(
  parameter int WIDTH    = VOTE_WIDTH,
  parameter int NUM_CAND = vote_pkg::NUM_CAND
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  start,
  input  logic [WIDTH-1:0]      cand1_vote_rec,
  input  logic [WIDTH-1:0]      cand2_vote_rec,
  input  logic [WIDTH-1:0]      cand3_vote_rec,
  input  logic [WIDTH-1:0]      cand4_vote_rec,
  input  logic                  out_ready,
  output logic                  result_valid,
  output logic [CAND_IDX_W-1:0] result_cand,
  output logic [WIDTH-1:0]      result_count,
  output logic                  winner_valid,
  output logic [CAND_IDX_W-1:0] winner_cand,
  output logic [WIDTH-1:0]      winner_count,
  output logic                  tie,
  output logic [WIDTH+1:0]      total_votes,
  output logic                  busy
);

  localparam logic [CAND_IDX_W-1:0] LAST_IDX = CAND_IDX_W'(NUM_CAND - 1);

  state_e                  state_q;
  logic [WIDTH-1:0]        snap_q [NUM_CAND];
  logic [CAND_IDX_W-1:0]   idx_q;

  // Working results of the scan; only copied to the outputs at the end.
  logic [WIDTH-1:0]        max_q;
  logic [CAND_IDX_W-1:0]   win_q;
  logic                    tie_work_q;
  logic [WIDTH+1:0]        sum_q;

  logic                    result_valid_q;
  logic [CAND_IDX_W-1:0]   result_cand_q;
  logic [WIDTH-1:0]        result_count_q;
  logic                    winner_valid_q;
  logic [CAND_IDX_W-1:0]   winner_cand_q;
  logic [WIDTH-1:0]        winner_count_q;
  logic                    tie_q;
  logic [WIDTH+1:0]        total_q;
  logic                    busy_q;

  logic [WIDTH-1:0]        live_cnt [NUM_CAND];
  logic [WIDTH-1:0]        cmp_count;
  logic [CAND_IDX_W-1:0]   next_cand;

  assign live_cnt[0] = cand1_vote_rec;
  assign live_cnt[1] = cand2_vote_rec;
  assign live_cnt[2] = cand3_vote_rec;
  assign live_cnt[3] = cand4_vote_rec;

  assign cmp_count = snap_q[idx_q];
  assign next_cand = result_cand_q + 2'd1;

  // Sequencer: snapshot, scan, report, publish.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
      idx_q          <= '0;
      max_q          <= '0;
      win_q          <= '0;
      tie_work_q     <= 1'b0;
      sum_q          <= '0;
      result_valid_q <= 1'b0;
      result_cand_q  <= '0;
      result_count_q <= '0;
      winner_valid_q <= 1'b0;
      winner_cand_q  <= '0;
      winner_count_q <= '0;
      tie_q          <= 1'b0;
      total_q        <= '0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and DONE behave alike: mode=0 clears everything, start restarts.
        ST_IDLE, ST_DONE: begin
          if (!mode) begin
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            result_cand_q  <= '0;
            result_count_q <= '0;
            winner_valid_q <= 1'b0;
            winner_cand_q  <= '0;
            winner_count_q <= '0;
            tie_q          <= 1'b0;
            total_q        <= '0;
            busy_q         <= 1'b0;
          end else if (start) begin
            state_q        <= ST_COMPARE;
            for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= live_cnt[i];
            idx_q          <= '0;
            max_q          <= '0;
            win_q          <= '0;
            tie_work_q     <= 1'b0;
            sum_q          <= '0;
            result_valid_q <= 1'b0;
            result_cand_q  <= '0;
            result_count_q <= '0;
            winner_valid_q <= 1'b0;
            winner_cand_q  <= '0;
            winner_count_q <= '0;
            tie_q          <= 1'b0;
            total_q        <= '0;
            busy_q         <= 1'b1;
          end else begin
            state_q <= state_q;
          end
        end

        ST_COMPARE: begin
          if (!mode) begin
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end else begin
            sum_q <= sum_q + {2'b00, cmp_count};
            // First candidate seeds the maximum; ties keep the lowest index.
            if ((idx_q == '0) || (cmp_count > max_q)) begin
              max_q      <= cmp_count;
              win_q      <= idx_q;
              tie_work_q <= 1'b0;
            end else if (cmp_count == max_q) begin
              tie_work_q <= 1'b1;
            end else begin
              tie_work_q <= tie_work_q;
            end
            if (idx_q == LAST_IDX) begin
              state_q        <= ST_REPORT;
              result_valid_q <= 1'b1;
              result_cand_q  <= '0;
              result_count_q <= snap_q[0];
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end

        ST_REPORT: begin
          if (!mode) begin
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end else if (out_ready) begin
            if (result_cand_q == LAST_IDX) begin
              state_q        <= ST_DONE;
              result_valid_q <= 1'b0;
              winner_valid_q <= 1'b1;
              winner_cand_q  <= win_q;
              winner_count_q <= max_q;
              tie_q          <= tie_work_q;
              total_q        <= sum_q;
              busy_q         <= 1'b0;
            end else begin
              // Next beat is presented straight away, no bubble.
              result_cand_q  <= next_cand;
              result_count_q <= snap_q[next_cand];
            end
          end else begin
            result_valid_q <= result_valid_q;
          end
        end

        default: begin
          state_q        <= ST_IDLE;
          result_valid_q <= 1'b0;
          winner_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign result_cand  = result_cand_q;
  assign result_count = result_count_q;
  assign winner_valid = winner_valid_q;
  assign winner_cand  = winner_cand_q;
  assign winner_count = winner_count_q;
  assign tie          = tie_q;
  assign total_votes  = total_q;
  assign busy         = busy_q;

endmodule : vote_result_reader

// File: tb/tb_vote_result_reader.sv
module tb_vote_result_reader;

  typedef logic [7:0] cnt_t [4];

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       start;
  logic       out_ready;
  logic [7:0] c1, c2, c3, c4;
  logic       result_valid;
  logic [1:0] result_cand;
  logic [7:0] result_count;
  logic       winner_valid;
  logic [1:0] winner_cand;
  logic [7:0] winner_count;
  logic       tie;
  logic [9:0] total_votes;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  vote_result_reader #(.WIDTH(8), .NUM_CAND(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .start          (start),
    .cand1_vote_rec (c1),
    .cand2_vote_rec (c2),
    .cand3_vote_rec (c3),
    .cand4_vote_rec (c4),
    .out_ready      (out_ready),
    .result_valid   (result_valid),
    .result_cand    (result_cand),
    .result_count   (result_count),
    .winner_valid   (winner_valid),
    .winner_cand    (winner_cand),
    .winner_count   (winner_count),
    .tie            (tie),
    .total_votes    (total_votes),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: highest value, first index holding it, how many share it, sum.
  task automatic ref_model(input cnt_t c, output int wc, output int wcnt,
                           output int tie_e, output int tot);
    int n_max;
    wcnt = 0; wc = 0; tot = 0; n_max = 0;
    foreach (c[i]) begin
      tot += int'(c[i]);
      if (int'(c[i]) > wcnt) wcnt = int'(c[i]);
    end
    for (int i = 3; i >= 0; i--)
      if (int'(c[i]) == wcnt) begin
        wc = i;
        n_max++;
      end
    tie_e = (n_max >= 2) ? 1 : 0;
  endtask

  task automatic set_live(input cnt_t c);
    c1 = c[0]; c2 = c[1]; c3 = c[2]; c4 = c[3];
  endtask

  task automatic scramble_live();
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
  endtask

  // Issue start and walk through the scan; returns at the cycle the first beat shows.
  task automatic start_seq(input cnt_t c, input bit poke_start);
    @(negedge clock);
    set_live(c); mode = 1'b1; start = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    scramble_live();
    check_val("busy_after_start", busy, 1);
    check_val("wv_after_start", winner_valid, 0);
    check_val("total_cleared", total_votes, 0);
    check_val("wcnt_cleared", winner_count, 0);
    for (int i = 1; i <= 3; i++) begin
      start = (poke_start && i == 2) ? 1'b1 : 1'b0;
      @(negedge clock);
      scramble_live();
      check_val("no_valid_in_compare", result_valid, 0);
      check_val("busy_in_compare", busy, 1);
    end
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_seq(input cnt_t c, input int stall_pct, input int stall_beat,
                         input bit poke_start);
    int b, guard, hold, wc, wcnt, tie_e, tot;
    bit rdy;
    ref_model(c, wc, wcnt, tie_e, tot);
    start_seq(c, poke_start);
    b = 0; guard = 0; hold = 0;
    while (b < 4 && guard < 200) begin
      check_val("beat_valid", result_valid, 1);
      check_val("beat_cand", result_cand, b);
      check_val("beat_count", result_count, c[b]);
      check_val("busy_report", busy, 1);
      check_val("wv_report", winner_valid, 0);
      rdy = ($urandom_range(99) >= stall_pct);
      if (b == stall_beat && hold < 3) begin
        rdy = 1'b0;
        hold++;
      end
      out_ready = rdy;
      scramble_live();
      @(negedge clock);
      if (rdy) b++;
      guard++;
    end
    check_val("beats_done", b, 4);
    if (stall_pct == 0 && stall_beat < 0) check_val("beat_cycles", guard, 4);
    out_ready = 1'b0;
    check_val("end_valid", result_valid, 0);
    check_val("end_busy", busy, 0);
    check_val("winner_valid", winner_valid, 1);
    check_val("winner_cand", winner_cand, wc);
    check_val("winner_count", winner_count, wcnt);
    check_val("tie", tie, tie_e);
    check_val("total_votes", total_votes, tot);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rv"}, result_valid, 0);
    check_val({tag, "_rc"}, result_cand, 0);
    check_val({tag, "_rn"}, result_count, 0);
    check_val({tag, "_wv"}, winner_valid, 0);
    check_val({tag, "_wc"}, winner_cand, 0);
    check_val({tag, "_wn"}, winner_count, 0);
    check_val({tag, "_tie"}, tie, 0);
    check_val({tag, "_tot"}, total_votes, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    cnt_t c;
    reset = 1'b0; mode = 1'b0; start = 1'b0; out_ready = 1'b0;
    c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // start is ignored in voting mode
    @(negedge clock);
    c1 = 8'd7; mode = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_all_zero("mode0_start");

    // Directed cases
    c = '{8'd5, 8'd9, 8'd3, 8'd7};     run_seq(c, 0, -1, 1'b0);
    c = '{8'd4, 8'd8, 8'd8, 8'd2};     run_seq(c, 0, -1, 1'b0);
    c = '{8'd1, 8'd2, 8'd3, 8'd4};     run_seq(c, 0, 2, 1'b0);
    c = '{8'd0, 8'd0, 8'd0, 8'd0};     run_seq(c, 0, -1, 1'b0);
    c = '{8'd255, 8'd255, 8'd255, 8'd255}; run_seq(c, 0, -1, 1'b1);

    // DONE with mode dropped clears the winner outputs
    @(negedge clock);
    mode = 1'b0;
    @(negedge clock);
    check_all_zero("done_mode0");

    // Abort while beat 1 is pending, then a clean re-run
    c = '{8'd11, 8'd22, 8'd33, 8'd44};
    start_seq(c, 1'b0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_val("abort_pending_cand", result_cand, 1);
    check_val("abort_pending_valid", result_valid, 1);
    mode = 1'b0;
    @(negedge clock);
    check_val("abort_valid", result_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_wv", winner_valid, 0);
    check_val("abort_tot", total_votes, 0);
    c = '{8'd6, 8'd6, 8'd1, 8'd9};     run_seq(c, 0, -1, 1'b0);

    // Asynchronous reset in the middle of REPORT
    c = '{8'd3, 8'd1, 8'd4, 8'd1};
    start_seq(c, 1'b0);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b1;

    // Randomized sequences, biased toward ties by sometimes using a tiny range
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        c[i] = (n % 3 == 0) ? 8'($urandom_range(3)) : 8'($urandom);
      run_seq(c, int'($urandom_range(60)), -1, 1'($urandom));
      if ($urandom_range(3) == 0) begin
        @(negedge clock);
        mode = 1'b0;
        @(negedge clock);
        check_val("rand_mode0_wv", winner_valid, 0);
        check_val("rand_mode0_tot", total_votes, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vote_result_reader

// File: doc/vote_result_reader.md
Name: vote_result_reader

Overview:
Read-side counterpart to the vote logging block. In result mode (mode=1), a start pulse triggers a one-cycle snapshot of the four candidate vote counters. The block then scans the snapshot for winner, tie and total, and streams each candidate's count to the display/UART path over a valid/ready handshake. It sits between the vote counters and the result display logic.

Parameters:
WIDTH, 8, width of each candidate vote count.
NUM_CAND, 4, number of candidates; fixed at 4, present for package consistency.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-low reset; clears all state and outputs immediately.
mode  in  1  0 = voting, 1 = result; the block operates only while mode=1.
start  in  1  single-cycle request to read and report results.
cand1_vote_rec..cand4_vote_rec  in  WIDTH each  live vote counts from the logger.
out_ready  in  1  downstream accepts the current result beat.
result_valid  out  1  result_cand/result_count hold a valid beat.
result_cand  out  2  candidate index of the current beat (0..3).
result_count  out  WIDTH  snapshot count for result_cand.
winner_valid  out  1  winner outputs are final.
winner_cand  out  2  index of the highest count.
winner_count  out  WIDTH  highest count.
tie  out  1  at least two candidates share the highest count.
total_votes  out  WIDTH+2  sum of the four snapshot counts.
busy  out  1  read/report sequence in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output is 0; snapshot registers are 0.
- States: IDLE, COMPARE, REPORT, DONE.
- IDLE: when start=1 and mode=1 at edge k, snapshot all four counts, clear max/tie/total, set idx=0 and go to COMPARE. busy=1 from edge k. start is ignored when mode=0.
- COMPARE: one candidate per cycle, at edges k+1..k+4, idx 0..3.
  - Add the snapshot count to total (no overflow possible; max 1020).
  - idx=0: always load max=count0, winner=0, tie=0.
  - Later idx, count > max: load the new max and winner, clear tie.
  - Later idx, count == max: set tie; the winner stays at the lowest index.
  - After idx=3, go to REPORT with result_valid=1, result_cand=0, result_count=snapshot[0].
- REPORT: a beat transfers on an edge where result_valid and out_ready are both 1.
  - While out_ready=0, result_cand and result_count hold stable.
  - After a transfer the next beat appears on the following cycle with no bubble.
  - With out_ready held at 1, beats transfer at edges k+5..k+8.
  - After the beat-3 transfer: result_valid=0, winner_valid=1, busy=0, go to DONE.
- DONE: winner outputs and total_votes hold.
  - start with mode=1: the outputs clear and a new sequence begins, same as from IDLE.
  - mode=0: all outputs clear, go to IDLE.
- Abort: mode=0 in COMPARE or REPORT gives next-edge IDLE with result_valid, winner_valid and busy all 0. An in-flight beat is dropped.
- start while busy is ignored.
- Live counter changes after the snapshot edge have no effect on the report.
- All counts zero: winner_cand=0, winner_count=0, tie=1, total_votes=0.
- winner_cand, winner_count, tie and total_votes read 0 whenever winner_valid=0.

Decomposition:
- Shared package (vote_pkg): NUM_CAND, CAND_IDX_W=2, state enum (IDLE/COMPARE/REPORT/DONE), total-width constant WIDTH+2.
- No sub-module is required. The compare/accumulate step stays inline; the FSM and datapath fit comfortably in one module.

Test Plan:
1. Counts 5,9,3,7; mode=1; start; out_ready=1 -> beats (0,5)(1,9)(2,3)(3,7) at edges k+5..k+8; then winner_cand=1, winner_count=9, tie=0, total_votes=24, winner_valid=1, busy=0.
2. Counts 4,8,8,2 -> winner_cand=1, winner_count=8, tie=1, total_votes=22.
3. Counts 1,2,3,4 with out_ready=0 for 3 cycles during beat 2 -> result_cand=2, result_count=3 held stable for 3 cycles; no beat lost or duplicated; winner_cand=3 at the end.
4. mode dropped to 0 while beat 1 is pending -> next cycle result_valid=0, busy=0, winner_valid=0; a later start with mode=1 re-runs the full sequence correctly.
5. All counts 0 -> four beats with count 0; winner_cand=0, winner_count=0, tie=1, total_votes=0.
6. Snapshot isolation and robustness:
   - Counts 255,255,255,255; change the live cand1 count to 10 right after start -> beat 0 reports 255; total_votes=1020; tie=1.
   - A second start during COMPARE is ignored.
   - reset asserted mid-REPORT clears all outputs immediately, without waiting for a clock edge.
